// File: rtl/nvme_pcie_pkg.sv
// Shared NVMe/PCIe definitions: RQ arbiter states, RQ tuser field offsets and
// the requester index map used by the RQ arbiter.
package nvme_pcie_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_XFER = 2'd1
  } arb_state_t;

  // RQ tuser layout (low bits): first_be[3:0], last_be[7:4], addr_offset[10:8], discontinue[11]
  localparam int RQ_TUSER_FIRST_BE_LSB = 0;
  localparam int RQ_TUSER_LAST_BE_LSB  = 4;
  localparam int RQ_TUSER_BE_W         = 4;
  localparam int RQ_TUSER_DISCONTINUE  = 11;

  localparam int RQ_REQ_DOORBELL = 0;

endpackage

// File: rtl/rr_select.sv
// Combinational rotate-priority picker: returns the first set bit of i_valid
// found searching upward from i_ptr, wrapping modulo N.
module rr_select
  import nvme_pcie_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    i_valid,
  input  logic [ID_W-1:0] i_ptr,
  output logic [ID_W-1:0] o_idx,
  output logic            o_found
);

  localparam logic [ID_W:0] N_W = (ID_W + 1)'(N);

  logic [2*N-1:0]  w_dbl;
  logic [N-1:0]    w_rot;
  logic [ID_W-1:0] w_off;
  logic [ID_W:0]   w_sum;
  logic [ID_W:0]   w_wrap;

  // Doubling the vector turns the wrap-around search into a plain part-select.
  assign w_dbl = {i_valid, i_valid};
  assign w_rot = w_dbl[{1'b0, i_ptr} +: N];

  always_comb begin
    w_off   = '0;
    o_found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off   = ID_W'(k);
        o_found = 1'b1;
      end
    end
  end

  assign w_sum  = {1'b0, i_ptr} + {1'b0, w_off};
  assign w_wrap = (w_sum >= N_W) ? (w_sum - N_W) : w_sum;
  assign o_idx  = w_wrap[ID_W-1:0];

endmodule

// File: rtl/rq_arbiter.sv
// Packet-level round-robin arbiter sharing the PCIe RQ AXI4-Stream port between
// NUM_REQ requesters. Define RQ_ARB_PRIO0_EN to give requester 0 strict priority.
module rq_arbiter
  import nvme_pcie_pkg::*;
#(
  parameter int NUM_REQ             = 4,
  parameter int C_DATA_WIDTH        = 128,
  parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int AXI4_RQ_TUSER_WIDTH = 62,
  parameter int ID_W                = $clog2(NUM_REQ)
) (
  input  logic                                   user_clk,
  input  logic                                   user_reset,
  input  logic                                   user_lnk_up,
  input  logic [NUM_REQ*C_DATA_WIDTH-1:0]        req_tdata,
  input  logic [NUM_REQ*AXI4_RQ_TUSER_WIDTH-1:0] req_tuser,
  input  logic [NUM_REQ*KEEP_WIDTH-1:0]          req_tkeep,
  input  logic [NUM_REQ-1:0]                     req_tlast,
  input  logic [NUM_REQ-1:0]                     req_tvalid,
  output logic [NUM_REQ-1:0]                     req_tready,
  output logic [C_DATA_WIDTH-1:0]                s_axis_rq_tdata,
  output logic [AXI4_RQ_TUSER_WIDTH-1:0]         s_axis_rq_tuser,
  output logic [KEEP_WIDTH-1:0]                  s_axis_rq_tkeep,
  output logic                                   s_axis_rq_tlast,
  output logic                                   s_axis_rq_tvalid,
  input  logic [3:0]                             s_axis_rq_tready,
  output logic [ID_W-1:0]                        grant_id,
  output logic [1:0]                             arb_state
);

  arb_state_t r_state;
  arb_state_t w_state_next;

  logic [ID_W-1:0]                r_grant;
  logic [ID_W-1:0]                r_rr_ptr;
  logic [C_DATA_WIDTH-1:0]        r_tdata;
  logic [AXI4_RQ_TUSER_WIDTH-1:0] r_tuser;
  logic [KEEP_WIDTH-1:0]          r_tkeep;
  logic                           r_tlast;
  logic                           r_tvalid;

  logic [C_DATA_WIDTH-1:0]        w_tdata_arr [NUM_REQ];
  logic [AXI4_RQ_TUSER_WIDTH-1:0] w_tuser_arr [NUM_REQ];
  logic [KEEP_WIDTH-1:0]          w_tkeep_arr [NUM_REQ];

  logic [NUM_REQ-1:0] w_rr_valid;
  logic [ID_W-1:0]    w_rr_idx;
  logic               w_rr_found;
  logic [ID_W-1:0]    w_pick_idx;
  logic               w_pick_found;
  logic               w_ptr_adv;
  logic [ID_W-1:0]    w_rr_next;
  logic               w_out_free;
  logic               w_accept;
  logic               w_sel_tlast;
  logic               w_unused_tready_hi;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_tdata_arr[gi] = req_tdata[gi*C_DATA_WIDTH +: C_DATA_WIDTH];
      assign w_tuser_arr[gi] = req_tuser[gi*AXI4_RQ_TUSER_WIDTH +: AXI4_RQ_TUSER_WIDTH];
      assign w_tkeep_arr[gi] = req_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
    end
  endgenerate

`ifdef RQ_ARB_PRIO0_EN
  // Doorbell requester bypasses the rotation and never moves the pointer.
  always_comb begin
    w_rr_valid                  = req_tvalid;
    w_rr_valid[RQ_REQ_DOORBELL] = 1'b0;
  end
  assign w_pick_idx   = req_tvalid[RQ_REQ_DOORBELL] ? ID_W'(RQ_REQ_DOORBELL) : w_rr_idx;
  assign w_pick_found = req_tvalid[RQ_REQ_DOORBELL] | w_rr_found;
  assign w_ptr_adv    = (r_grant != ID_W'(RQ_REQ_DOORBELL));
`else
  assign w_rr_valid   = req_tvalid;
  assign w_pick_idx   = w_rr_idx;
  assign w_pick_found = w_rr_found;
  assign w_ptr_adv    = 1'b1;
`endif

  rr_select #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr_select (
    .i_valid (w_rr_valid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_rr_idx),
    .o_found (w_rr_found)
  );

  assign w_rr_next   = (r_grant == ID_W'(NUM_REQ - 1)) ? '0 : r_grant + ID_W'(1);
  assign w_out_free  = !r_tvalid || s_axis_rq_tready[0];
  assign w_sel_tlast = req_tlast[r_grant];
  assign w_accept    = (r_state == ARB_XFER) && user_lnk_up && w_out_free && req_tvalid[r_grant];

  // Link-down gating keeps a beat from being consumed in the cycle it is flushed.
  always_comb begin
    req_tready = '0;
    if (r_state == ARB_XFER && user_lnk_up) begin
      req_tready[r_grant] = w_out_free;
    end
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARB_IDLE: if (w_pick_found) w_state_next = ARB_XFER;
      ARB_XFER: if (w_accept && w_sel_tlast) w_state_next = ARB_IDLE;
      default:  w_state_next = ARB_IDLE;
    endcase
    if (!user_lnk_up) begin
      w_state_next = ARB_IDLE;
    end
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_tdata  <= '0;
      r_tuser  <= '0;
      r_tkeep  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
    end else if (!user_lnk_up) begin
      r_tvalid <= 1'b0;
    end else begin
      if (r_state == ARB_IDLE && w_pick_found) begin
        r_grant <= w_pick_idx;
      end
      if (w_accept) begin
        r_tdata  <= w_tdata_arr[r_grant];
        r_tuser  <= w_tuser_arr[r_grant];
        r_tkeep  <= w_tkeep_arr[r_grant];
        r_tlast  <= w_sel_tlast;
        r_tvalid <= 1'b1;
        if (w_sel_tlast && w_ptr_adv) begin
          r_rr_ptr <= w_rr_next;
        end
      end else if (w_out_free) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign w_unused_tready_hi = ^s_axis_rq_tready[3:1];

  assign s_axis_rq_tdata  = r_tdata;
  assign s_axis_rq_tuser  = r_tuser;
  assign s_axis_rq_tkeep  = r_tkeep;
  assign s_axis_rq_tlast  = r_tlast;
  assign s_axis_rq_tvalid = r_tvalid;
  assign grant_id         = r_grant;
  assign arb_state        = r_state;

endmodule

// File: tb/tb_rq_arbiter.sv
// Scoreboard bench for rq_arbiter: beats accepted from requesters are queued
// and compared against what appears on the RQ output; grant order is scripted.
module tb_rq_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 128;
  localparam int KW      = DW / 32;
  localparam int UW      = 62;
  localparam int IDW     = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  user_lnk_up;
  logic [NUM_REQ*DW-1:0] req_tdata;
  logic [NUM_REQ*UW-1:0] req_tuser;
  logic [NUM_REQ*KW-1:0] req_tkeep;
  logic [NUM_REQ-1:0]    req_tlast;
  logic [NUM_REQ-1:0]    req_tvalid;
  logic [NUM_REQ-1:0]    req_tready;
  logic [DW-1:0]         s_axis_rq_tdata;
  logic [UW-1:0]         s_axis_rq_tuser;
  logic [KW-1:0]         s_axis_rq_tkeep;
  logic                  s_axis_rq_tlast;
  logic                  s_axis_rq_tvalid;
  logic [3:0]            s_axis_rq_tready;
  logic [IDW-1:0]        grant_id;
  logic [1:0]            arb_state;

  rq_arbiter #(
    .NUM_REQ             (NUM_REQ),
    .C_DATA_WIDTH        (DW),
    .KEEP_WIDTH          (KW),
    .AXI4_RQ_TUSER_WIDTH (UW),
    .ID_W                (IDW)
  ) dut (
    .user_clk         (clk),
    .user_reset       (rst),
    .user_lnk_up      (user_lnk_up),
    .req_tdata        (req_tdata),
    .req_tuser        (req_tuser),
    .req_tkeep        (req_tkeep),
    .req_tlast        (req_tlast),
    .req_tvalid       (req_tvalid),
    .req_tready       (req_tready),
    .s_axis_rq_tdata  (s_axis_rq_tdata),
    .s_axis_rq_tuser  (s_axis_rq_tuser),
    .s_axis_rq_tkeep  (s_axis_rq_tkeep),
    .s_axis_rq_tlast  (s_axis_rq_tlast),
    .s_axis_rq_tvalid (s_axis_rq_tvalid),
    .s_axis_rq_tready (s_axis_rq_tready),
    .grant_id         (grant_id),
    .arb_state        (arb_state)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
    int            id;
  } beat_t;

  beat_t              src_q [NUM_REQ][$];
  beat_t              exp_q [$];
  int                 exp_grant [$];
  logic [NUM_REQ-1:0] src_en;
  logic               core_rdy_v;
  logic               lnk_v;
  int                 n_cmp = 0;
  int                 n_err = 0;
  int                 cyc = 0;
  int                 pkt_seq = 0;
  bit                 out_in_pkt = 0;
  bit                 seen_prev = 0;
  bit                 gap_chk = 0;
  int                 last_start_cyc = 0;
  int                 last_end_cyc = 0;
  int                 t0;
  logic [DW-1:0]      b2;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pending();
    int s;
    s = exp_q.size() + exp_grant.size();
    for (int i = 0; i < NUM_REQ; i++) s += src_q[i].size();
    return s;
  endfunction

  task automatic add_pkt(input int id, input int nb);
    for (int b = 0; b < nb; b++) begin
      beat_t x;
      x.data = {$urandom, $urandom, $urandom, $urandom};
      x.data[127:104] = {8'(id), 8'(pkt_seq), 8'(b)};
      x.keep = 4'($urandom_range(1, 15));
      x.user = 62'({$urandom, $urandom});
      x.last = (b == nb - 1);
      x.id   = id;
      src_q[id].push_back(x);
    end
    pkt_seq++;
  endtask

  // One clock cycle: drive at the falling edge, sample 1 time unit later.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0 && src_en[i]) begin
        req_tvalid[i]          = 1'b1;
        req_tdata[i*DW +: DW]  = src_q[i][0].data;
        req_tuser[i*UW +: UW]  = src_q[i][0].user;
        req_tkeep[i*KW +: KW]  = src_q[i][0].keep;
        req_tlast[i]           = src_q[i][0].last;
      end else begin
        req_tvalid[i] = 1'b0;
        req_tlast[i]  = 1'b0;
      end
    end
    s_axis_rq_tready = {3'($urandom), core_rdy_v};
    user_lnk_up      = lnk_v;
    #1;
    check_eq("ready_onehot", ($countones(req_tready) <= 1), 1'b1);
    if (s_axis_rq_tvalid && s_axis_rq_tready[0]) begin
      if (exp_q.size() == 0) begin
        check_eq("beat_expected", s_axis_rq_tvalid, 1'b0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check_eq("out_data", s_axis_rq_tdata, e.data);
        check_eq("out_keep", s_axis_rq_tkeep, e.keep);
        check_eq("out_user", s_axis_rq_tuser, e.user);
        check_eq("out_last", s_axis_rq_tlast, e.last);
        if (!out_in_pkt) begin
          if (exp_grant.size() > 0) check_eq("grant_order", e.id, exp_grant.pop_front());
          else check_eq("grant_order", e.id, 32'hFFFF_FFFF);
          check_eq("grant_id", grant_id, e.id);
          if (gap_chk && seen_prev) check_eq("pkt_gap", cyc - last_start_cyc, 2);
          last_start_cyc = cyc;
          seen_prev      = 1;
        end
        if (e.last) last_end_cyc = cyc;
        out_in_pkt = !e.last;
        $display("[%0d] rq beat req=%0d last=%0b keep=%h data=%h", cyc, e.id, e.last,
                 s_axis_rq_tkeep, s_axis_rq_tdata);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_tvalid[i] && req_tready[i] && src_q[i].size() > 0) begin
        exp_q.push_back(src_q[i].pop_front());
      end
    end
    cyc++;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (pending() > 0 && n < 300) begin
      step();
      n++;
    end
    check_eq({tag, "_drained"}, pending(), 0);
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    exp_q.delete();
    exp_grant.delete();
    out_in_pkt = 0;
    seen_prev  = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    add_pkt(1, 1);
    repeat (3) step();
    check_eq("rst_tvalid", s_axis_rq_tvalid, 1'b0);
    check_eq("rst_tdata", s_axis_rq_tdata, '0);
    check_eq("rst_tkeep", s_axis_rq_tkeep, '0);
    check_eq("rst_tuser", s_axis_rq_tuser, '0);
    check_eq("rst_tlast", s_axis_rq_tlast, 1'b0);
    check_eq("rst_req_tready", req_tready, '0);
    check_eq("rst_grant_id", grant_id, '0);
    check_eq("rst_state", arb_state, 2'd0);
    clear_queues();
    req_tvalid = '0;
    req_tlast  = '0;
    rst        = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t x;
    rst              = 1'b1;
    lnk_v            = 1'b1;
    user_lnk_up      = 1'b1;
    core_rdy_v       = 1'b1;
    src_en           = '1;
    req_tdata        = '0;
    req_tuser        = '0;
    req_tkeep        = '0;
    req_tlast        = '0;
    req_tvalid       = '0;
    s_axis_rq_tready = '0;
    apply_reset();

    // Doorbell-style 2-beat packet from requester 2 with exact latency.
    x.data = 128'h0000_0000_0000_0001_0000_0004_0000_1008;
    x.keep = 4'b1111; x.user = 62'h0F; x.last = 1'b0; x.id = 2;
    src_q[2].push_back(x);
    x.data = 128'h0000_0005;
    x.keep = 4'b0001; x.user = 62'h0F; x.last = 1'b1; x.id = 2;
    src_q[2].push_back(x);
    exp_grant.push_back(2);
    t0 = cyc;
    drain("t1");
    check_eq("t1_first_latency", last_start_cyc - t0, 2);
    check_eq("t1_last_cycle", last_end_cyc - t0, 3);

    // Pointer now sits at 3: requesters 0 and 3 contend.
    add_pkt(0, 1);
    add_pkt(3, 1);
`ifdef RQ_ARB_PRIO0_EN
    exp_grant.push_back(0); exp_grant.push_back(3);
`else
    exp_grant.push_back(3); exp_grant.push_back(0);
`endif
    drain("t1_ptr");

    // Requesters 0, 1, 3 continuously valid with 1-beat packets.
    apply_reset();
    gap_chk = 1;
    for (int p = 0; p < 2; p++) begin
      add_pkt(0, 1);
      add_pkt(1, 1);
      add_pkt(3, 1);
    end
`ifdef RQ_ARB_PRIO0_EN
    foreach (x.keep[k]) begin end
    exp_grant = '{0, 0, 1, 3, 1, 3};
`else
    exp_grant = '{0, 1, 3, 0, 1, 3};
`endif
    drain("t2");
    gap_chk = 0;

    // Core backpressure on beat 2 of a 4-beat packet.
    add_pkt(2, 4);
    b2 = src_q[2][1].data;
    exp_grant.push_back(2);
    repeat (3) step();
    core_rdy_v = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("t4_hold_data", s_axis_rq_tdata, b2);
      check_eq("t4_hold_valid", s_axis_rq_tvalid, 1'b1);
      check_eq("t4_req_tready", req_tready, '0);
    end
    core_rdy_v = 1'b1;
    drain("t4");

    // Requester 1 stalls mid-packet; requester 2 must wait.
    add_pkt(1, 4);
    exp_grant.push_back(1);
    exp_grant.push_back(2);
    step();
    add_pkt(2, 1);
    step();
    src_en[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("t5_req2_tready", req_tready[2], 1'b0);
      check_eq("t5_grant_held", grant_id, 2'd1);
      check_eq("t5_state", arb_state, 2'd1);
    end
    src_en[1] = 1'b1;
    drain("t5");

    // Link drops mid-packet, then an asynchronous reset pulse.
    add_pkt(3, 4);
    exp_grant.push_back(3);
    repeat (3) step();
    lnk_v = 1'b0;
    step();
    step();
    check_eq("t6_flush_tvalid", s_axis_rq_tvalid, 1'b0);
    check_eq("t6_flush_tready", req_tready, '0);
    check_eq("t6_flush_state", arb_state, 2'd0);
    check_eq("t6_flush_grant", grant_id, 2'd3);
    clear_queues();
    #2 rst = 1'b1;
    #1;
    check_eq("t6_arst_tvalid", s_axis_rq_tvalid, 1'b0);
    check_eq("t6_arst_tdata", s_axis_rq_tdata, '0);
    check_eq("t6_arst_grant", grant_id, '0);
    check_eq("t6_arst_state", arb_state, 2'd0);
    rst   = 1'b0;
    lnk_v = 1'b1;
    add_pkt(2, 2);
    exp_grant.push_back(2);
    t0 = cyc;
    drain("t6");
    check_eq("t6_relink_latency", last_start_cyc - t0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rq_arbiter.md
# rq_arbiter

Packet-level arbiter sharing the PCIe core's Requester reQuest (RQ) AXI4-Stream port between `NUM_REQ` requester engines, e.g. the SQ/CQ doorbell writer and the PRP/data DMA engines. Once a requester is granted a packet, the grant is held until that packet's `tlast` beat is accepted. Arbitration is round-robin, with an optional strict-priority requester. One registered output stage sits between the selected requester and the core's RQ interface.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requester ports, 2..8.
- `C_DATA_WIDTH`, 128: RQ tdata width.
- `KEEP_WIDTH`, `C_DATA_WIDTH/32`: tkeep width.
- `AXI4_RQ_TUSER_WIDTH`, 62: RQ tuser width.
- `ID_W`, `$clog2(NUM_REQ)`: grant index width.

Ports:
- `user_clk` in, 1: sole clock.
- `user_reset` in, 1: reset, asynchronous, active-high.
- `user_lnk_up` in, 1: link up. Low acts as a synchronous flush.
- `req_tdata` in, `NUM_REQ*C_DATA_WIDTH`: flattened requester tdata; requester i occupies slice i.
- `req_tuser` in, `NUM_REQ*AXI4_RQ_TUSER_WIDTH`: flattened tuser.
- `req_tkeep` in, `NUM_REQ*KEEP_WIDTH`: flattened tkeep.
- `req_tlast` in, `NUM_REQ`: per-requester tlast.
- `req_tvalid` in, `NUM_REQ`: per-requester tvalid.
- `req_tready` out, `NUM_REQ`: per-requester tready. Combinational from state and output-stage status.
- `s_axis_rq_tdata` out, `C_DATA_WIDTH`: to PCIe core.
- `s_axis_rq_tuser` out, `AXI4_RQ_TUSER_WIDTH`: to PCIe core.
- `s_axis_rq_tkeep` out, `KEEP_WIDTH`: to PCIe core.
- `s_axis_rq_tlast` out, 1: to PCIe core.
- `s_axis_rq_tvalid` out, 1: to PCIe core.
- `s_axis_rq_tready` in, 4: core ready. Only bit 0 is used.
- `grant_id` out, `ID_W`: current or last granted requester.
- `arb_state` out, 2: debug state.

## Operation
States: `ARB_IDLE`=0, `ARB_XFER`=1.

`ARB_IDLE`:
- `req_tready` is all 0.
- If any `req_tvalid` is set, select the first valid requester searching from `rr_ptr` upward, wrapping modulo `NUM_REQ`.
- Register the selection into `grant_id` and go to `ARB_XFER`.

`ARB_XFER`:
- Define `out_free = !s_axis_rq_tvalid || s_axis_rq_tready[0]`.
- `req_tready[grant_id] = out_free`; all other ready bits are 0.
- An accepted beat (`req_tvalid[g] && req_tready[g]`) loads the output register: tdata, tuser, tkeep and tlast slices of g, with `s_axis_rq_tvalid` set to 1.
- If `out_free` and no beat is accepted, `s_axis_rq_tvalid` goes to 0.
- When the accepted beat has `tlast`=1: `rr_ptr` <= (g+1) mod `NUM_REQ`, and the next state is `ARB_IDLE`.

General rules:
- Packets are never interleaved. A granted requester that deasserts tvalid mid-packet holds the grant; there is no timeout.
- While `s_axis_rq_tvalid`=1 and `s_axis_rq_tready[0]`=0, all output registers hold their values.
- `user_lnk_up`=0: state goes to `ARB_IDLE`, `s_axis_rq_tvalid` to 0, `req_tready` to 0. `rr_ptr` and `grant_id` are kept. Any partial packet is dropped; requesters restart after link-up.
- Reset values: all `s_axis_rq_*` = 0, `req_tready` = 0, `grant_id` = 0, `rr_ptr` = 0, `arb_state` = `ARB_IDLE`.

## Timing
- Arbitration latency: requester tvalid rises in cycle 0 → grant registered at the end of cycle 0 → `req_tready` high in cycle 1 → beat on `s_axis_rq_*` in cycle 2.
- Throughput: one beat per cycle while a packet is in flight and the core is ready.
- Inter-packet bubble: one `ARB_IDLE` cycle between consecutive packets.
- The output stage is a single register, not a skid buffer. The ready path `s_axis_rq_tready[0]` → `req_tready` is combinational.
- Back-to-back beats while the core is ready produce no gaps.

## Configuration
- `RQ_ARB_PRIO0_EN` defined: in `ARB_IDLE`, requester 0 wins whenever its tvalid is set, regardless of `rr_ptr`. Granting requester 0 does not advance `rr_ptr`. Requesters 1..N-1 rotate round-robin among themselves. This is intended for doorbell latency.
- Macro undefined: pure round-robin over all `NUM_REQ` requesters.

## Structure
- Shared package `nvme_pcie_pkg` holds:
  - `ARB_IDLE`/`ARB_XFER` state constants;
  - RQ tuser field offsets (first_be, last_be, discontinue);
  - `RQ_REQ_DOORBELL`=0 requester index assignment.
- Sub-module `rr_select`: purely combinational rotate-priority picker. Inputs: valid vector and pointer. Outputs: index and found flag.
- The FSM and output register stay in `rq_arbiter`.

## Test plan
- Single requester 2 sends a 2-beat packet (doorbell: keep 4'b1111 then 4'b0001, data 0x0000_0005), core ready → `s_axis_rq` shows both beats in cycles 2–3 with tlast on beat 2; `rr_ptr` becomes 3.
- Requesters 0, 1 and 3 each hold a 1-beat packet continuously, macro off → grant order 0, 1, 3, 0, with one idle cycle between packets.
- Same stimulus with `RQ_ARB_PRIO0_EN` → requester 0 is always granted when valid; requesters 1 and 3 alternate otherwise.
- 4-beat packet with `s_axis_rq_tready[0]` low for 3 cycles on beat 2 → beat 2 is held stable, `req_tready` is 0, and no beat is lost or duplicated.
- Requester 1 drops tvalid for 5 cycles mid-packet while requester 2 is valid → requester 2 is not granted until requester 1's tlast is accepted.
- `user_lnk_up` drops mid-packet, then `user_reset` is pulsed asynchronously → outputs go to 0 as specified, state is `ARB_IDLE`, and a fresh request after link-up is granted normally.
